// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial FSM state encoding and the add/sub opcode
// encoding understood by the 1-bit AdderSubtractor cell.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/AdderSubtractor.sv
// 1-bit add/subtract cell: B is inverted for subtract, the caller seeds cin
// with 1 on the LSB so the chain forms A + ~B + 1.
module AdderSubtractor
  import alu_pkg::*;
(
  input  logic clk,
  input  logic A,
  input  logic B,
  input  logic op,
  input  logic cin,
  output logic result,
  output logic cout
);

  logic b_eff;
  logic unused_clk;

  // The cell is purely combinational; the clock pin exists only for pin compatibility.
  assign unused_clk = clk;

  assign b_eff  = B ^ (op == OP_SUB);
  assign result = A ^ b_eff ^ cin;
  assign cout   = (A & b_eff) | (cin & (A ^ b_eff));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one AdderSubtractor cell evaluated
// once per clock, LSB first, with valid/ready on both operand and result sides.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  serial_state_t    state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             sub_q;
  logic             carry_q;
  logic             c_msb_in_q;

  logic cell_res;
  logic cell_cout;

  AdderSubtractor u_cell (
    .clk    (clk),
    .A      (a_sh_q[0]),
    .B      (b_sh_q[0]),
    .op     (sub_q),
    .cin    (carry_q),
    .result (cell_res),
    .cout   (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Results enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
          res_sh_q <= {cell_res, res_sh_q[WIDTH-1:1]};
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          carry_q  <= cell_cout;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_MSB_IN) c_msb_in_q <= cell_cout;
          if (cnt_q == CNT_LAST)   state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_sh_q;
  assign carry     = carry_q;
  assign overflow  = c_msb_in_q ^ carry_q;
  assign zero      = ~|res_sh_q;

endmodule
